// File: rtl/tlul_err_resp_chk_if.sv
// Host A, device A handshake, device D and host D signals around the TL-UL error checker.
// Latency: none, this is a bundle of wires.
// Backpressure: carries the valid/ready pairs of both A and both D channels.
interface tlul_err_resp_chk_if #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int AIW = 8
) ();
  localparam int DBW   = DW / 8;
  localparam int MaxSz = $clog2(DBW);
  localparam int SZW   = $clog2(MaxSz + 1);

  logic             h_a_valid_i;
  logic [2:0]       h_a_opcode_i;
  logic [SZW-1:0]   h_a_size_i;
  logic [AIW-1:0]   h_a_source_i;
  logic [AW-1:0]    h_a_address_i;
  logic [DBW-1:0]   h_a_mask_i;
  logic             h_a_ready_o;

  logic             d_a_valid_o;
  logic             d_a_ready_i;

  logic             d_d_valid_i;
  logic [2:0]       d_d_opcode_i;
  logic [SZW-1:0]   d_d_size_i;
  logic [AIW-1:0]   d_d_source_i;
  logic [DW-1:0]    d_d_data_i;
  logic             d_d_error_i;
  logic             d_d_ready_o;

  logic             h_d_valid_o;
  logic [2:0]       h_d_opcode_o;
  logic [SZW-1:0]   h_d_size_o;
  logic [AIW-1:0]   h_d_source_o;
  logic [DW-1:0]    h_d_data_o;
  logic             h_d_error_o;
  logic             h_d_ready_i;

  logic             err_o;

  // Checker side.
  modport slave (
    input  h_a_valid_i, h_a_opcode_i, h_a_size_i, h_a_source_i, h_a_address_i, h_a_mask_i,
    output h_a_ready_o,
    output d_a_valid_o,
    input  d_a_ready_i,
    input  d_d_valid_i, d_d_opcode_i, d_d_size_i, d_d_source_i, d_d_data_i, d_d_error_i,
    output d_d_ready_o,
    output h_d_valid_o, h_d_opcode_o, h_d_size_o, h_d_source_o, h_d_data_o, h_d_error_o,
    input  h_d_ready_i,
    output err_o
  );

  // Host plus device side, as seen by whoever drives the checker.
  modport master (
    output h_a_valid_i, h_a_opcode_i, h_a_size_i, h_a_source_i, h_a_address_i, h_a_mask_i,
    input  h_a_ready_o,
    input  d_a_valid_o,
    output d_a_ready_i,
    output d_d_valid_i, d_d_opcode_i, d_d_size_i, d_d_source_i, d_d_data_i, d_d_error_i,
    input  d_d_ready_o,
    input  h_d_valid_o, h_d_opcode_o, h_d_size_o, h_d_source_o, h_d_data_o, h_d_error_o,
    output h_d_ready_i,
    input  err_o
  );
endinterface

// File: rtl/tlul_err_resp_chk.sv
// TL-UL A-channel legality checker: legal requests go to the device, illegal ones get a local d_error.
// Latency: legal A and all device D traffic are combinational pass-through; error response >= 1 cycle after A.
// Backpressure: host A stalls at MaxOutstanding or while draining/responding; D ready follows host D ready.
module tlul_err_resp_chk #(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int AIW            = 8,
  parameter int MaxOutstanding = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tlul_err_resp_chk_if.slave tl
);
  localparam int DBW   = DW / 8;
  localparam int MaxSz = $clog2(DBW);
  localparam int SZW   = $clog2(MaxSz + 1);
  localparam int CW    = $clog2(MaxOutstanding + 1);
  localparam int OffW  = (MaxSz < AW) ? MaxSz : AW;

  localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

  localparam logic [2:0] OpPutFull       = 3'd0;
  localparam logic [2:0] OpPutPartial    = 3'd1;
  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AIW-1:0]  cap_source_q;
  logic [SZW-1:0]  cap_size_q;
  logic [2:0]      cap_opcode_q;
  logic            cap_en;

  int              sz_val, nbytes, addr_off, base;
  logic [DBW-1:0]  win;
  logic            size_ok, align_ok, op_ok, mask_in, full_ok, legal;
  logic            cnt_lt, fwd_ok, inc, dec;

  // Byte window covered by the request and the alignment/size tests behind it.
  always_comb begin
    sz_val   = int'(tl.h_a_size_i);
    size_ok  = (sz_val <= MaxSz);
    nbytes   = 1 << sz_val;
    addr_off = int'(tl.h_a_address_i[OffW-1:0]);
    align_ok = ((addr_off & (nbytes - 1)) == 0);
    base     = addr_off & ~(nbytes - 1);
    win      = '0;
    for (int i = 0; i < DBW; i++) begin
      win[i] = (i >= base) && (i < base + nbytes);
    end
  end

  assign op_ok   = (tl.h_a_opcode_i == OpPutFull) || (tl.h_a_opcode_i == OpPutPartial) ||
                   (tl.h_a_opcode_i == OpGet);
  assign mask_in = ((tl.h_a_mask_i & ~win) == '0);
  // Only a full write has to light every byte of its window.
  assign full_ok = (tl.h_a_opcode_i != OpPutFull) || (tl.h_a_mask_i == win);
  assign legal   = op_ok && size_ok && align_ok && mask_in && full_ok;
  assign tl.err_o = tl.h_a_valid_i & ~legal;

  // Issue/retire qualifiers are built from state and inputs only, so the FSM can look at cnt_d
  // without a combinational loop through its own outputs.
  assign cnt_lt = (cnt_q < MaxCnt);
  assign fwd_ok = (state_q == IDLE) && legal && cnt_lt;
  assign inc    = fwd_ok && tl.h_a_valid_i && tl.d_a_ready_i;
  assign dec    = (state_q != RESP) && tl.d_d_valid_i && tl.h_d_ready_i;

  // Outstanding count: simultaneous issue and retire cancel out.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc, dec})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Next state and all handshake/D-channel outputs.
  always_comb begin
    state_d         = state_q;
    cap_en          = 1'b0;
    tl.h_a_ready_o  = 1'b0;
    tl.d_a_valid_o  = 1'b0;
    tl.d_d_ready_o  = tl.h_d_ready_i;
    tl.h_d_valid_o  = tl.d_d_valid_i;
    tl.h_d_opcode_o = tl.d_d_opcode_i;
    tl.h_d_size_o   = tl.d_d_size_i;
    tl.h_d_source_o = tl.d_d_source_i;
    tl.h_d_data_o   = tl.d_d_data_i;
    tl.h_d_error_o  = tl.d_d_error_i;
    unique case (state_q)
      IDLE: begin
        if (legal) begin
          tl.d_a_valid_o = tl.h_a_valid_i & cnt_lt;
          tl.h_a_ready_o = tl.d_a_ready_i & cnt_lt;
        end else begin
          // Illegal requests are swallowed here and never reach the device.
          tl.h_a_ready_o = 1'b1;
          if (tl.h_a_valid_i) begin
            cap_en  = 1'b1;
            state_d = (cnt_d == '0) ? RESP : DRAIN;
          end
        end
      end
      DRAIN: begin
        // Earlier device responses must reach the host before our error.
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        tl.d_d_ready_o  = 1'b0;
        tl.h_d_valid_o  = 1'b1;
        tl.h_d_opcode_o = (cap_opcode_q == OpGet) ? OpAccessAckData : OpAccessAck;
        tl.h_d_size_o   = cap_size_q;
        tl.h_d_source_o = cap_source_q;
        tl.h_d_data_o   = '1;
        tl.h_d_error_o  = 1'b1;
        if (tl.h_d_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and outstanding counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fields echoed back in the error response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_source_q <= '0;
      cap_size_q   <= '0;
      cap_opcode_q <= '0;
    end else if (cap_en) begin
      cap_source_q <= tl.h_a_source_i;
      cap_size_q   <= tl.h_a_size_i;
      cap_opcode_q <= tl.h_a_opcode_i;
    end
  end

  cnt_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) dec |-> (cnt_q != '0));
  cnt_overflow_a:  assert property (@(posedge clk_i) disable iff (!rst_ni) inc |-> (cnt_q != MaxCnt));
endmodule
